// File: rtl/shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult (with helper ripple_carry_n)
// Description : Unsigned N x N iterative shift-and-add multiplier producing a
//               2N-bit product. One partial-product step per clock through a
//               ripple-carry adder; a multiply occupies N RUN cycles plus one
//               DONE cycle, so the issue period is N+2 cycles.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               start  - multiply request, sampled only in IDLE
//               a, b   - multiplicand / multiplier (captured on accept)
//               busy   - high while stepping (RUN)
//               done   - single-cycle completion pulse (DONE)
//               p      - product register, updated only on completion
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// ripple_carry_n : N-bit ripple-carry adder, purely combinational.
// ----------------------------------------------------------------------------
module ripple_carry_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            assign sum[i]       = a[i] ^ b[i] ^ carry[i];
            assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = carry[N];

endmodule

// ----------------------------------------------------------------------------
// shift_add_mult : iterative multiplier top level.
// ----------------------------------------------------------------------------
module shift_add_mult #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int                  CNT_W    = $clog2(N + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]     mcand;
    logic [N-1:0]     acc_hi;
    logic [N-1:0]     acc_lo;
    logic [CNT_W-1:0] cnt;

    logic [N-1:0]     addend;
    logic [N-1:0]     sum;
    logic             cout;
    logic [2*N-1:0]   step_val;
    logic             accept;
    logic             last_step;

    // The low accumulator half doubles as the multiplier shift register:
    // its LSB selects whether the multiplicand is added on this step.
    assign addend = acc_lo[0] ? mcand : '0;

    ripple_carry_n #(
        .N    (N)
    ) u_adder (
        .a    (acc_hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Carry-out lands in the top bit of the shifted accumulator, so the
    // partial product can never overflow its 2N bits.
    assign step_val  = {cout, sum, acc_lo[N-1:1]};
    assign accept    = (state == IDLE) && start;
    assign last_step = (state == RUN) && (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == CNT_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            p      <= '0;
        end else begin
            if (accept) begin
                mcand  <= a;
                acc_hi <= '0;
                acc_lo <= b;
                cnt    <= '0;
            end else if (state == RUN) begin
                {acc_hi, acc_lo} <= step_val;
                cnt              <= cnt + CNT_ONE;
            end
            if (last_step) begin
                p <= step_val;
            end
        end
    end

    // Status outputs come straight from the state register.
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_mult
// Description : Self-checking bench for shift_add_mult. Drives an N=4 and an
//               N=8 instance with directed operands and hand-computed
//               products; checks reset state, latency, busy width, done
//               pulse width, product hold, start-held behaviour and reset
//               abandoning an in-flight multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult;

    logic        clk;
    logic        rst_n;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        busy4;
    logic        done4;
    logic [7:0]  p4;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] p8;

    int total_checks;
    int passed_checks;

    shift_add_mult #(.N(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .p     (p4)
    );

    shift_add_mult #(.N(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .p     (p8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got === exp) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One multiply on the selected instance; start pulsed for one cycle.
    task automatic run_mult(input bit wide, input logic [7:0] av, input logic [7:0] bv,
                            input logic [15:0] exp, input string tag);
        int cycles;
        int busy_cycles;
        bit seen;
        int n;
        n           = wide ? 8 : 4;
        cycles      = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        @(negedge clk);
        if (wide) begin a8 = av; b8 = bv; start8 = 1'b1; end
        else      begin a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1; end
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start8 = 1'b0;
        // Scramble operands: the block must use its captured copies.
        a4 = ~a4; b4 = ~b4; a8 = ~a8; b8 = ~b8;
        while (!seen && cycles < 30) begin
            @(negedge clk);
            cycles++;
            if (wide ? busy8 : busy4) busy_cycles++;
            if (wide ? done8 : done4) seen = 1'b1;
        end
        check({tag, "_latency"}, cycles, n + 1);
        check({tag, "_busy"}, busy_cycles, n);
        check({tag, "_p"}, wide ? {16'd0, p8} : {24'd0, p4}, {16'd0, exp});
        @(negedge clk);
        check({tag, "_done_width"}, wide ? done8 : done4, 0);
        check({tag, "_p_hold"}, wide ? {16'd0, p8} : {24'd0, p4}, {16'd0, exp});
    endtask

    initial begin
        int cycles;
        total_checks  = 0;
        passed_checks = 0;
        rst_n  = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_p", p4, 0);
        check("rst_p8", p8, 0);
        rst_n = 1'b1;

        // N=4 directed
        run_mult(1'b0, 8'd3, 8'd5, 16'd15, "m3x5");
        repeat (3) @(negedge clk);
        check("m3x5_p_idle", p4, 15);
        run_mult(1'b0, 8'd15, 8'd15, 16'd225, "m15x15");
        run_mult(1'b0, 8'd0, 8'd9, 16'd0, "m0x9");
        run_mult(1'b0, 8'd9, 8'd0, 16'd0, "m9x0");

        // start held high; operands change during RUN
        @(negedge clk);
        a4 = 4'd7; b4 = 4'd6; start4 = 1'b1;
        @(posedge clk);
        #1;
        a4 = 4'd2; b4 = 4'd2;
        cycles = 0;
        while (!done4 && cycles < 30) begin
            @(negedge clk);
            cycles++;
        end
        check("held_lat1", cycles, 5);
        check("held_p1", p4, 42);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 3) check("held_p_during_run", p4, 42);
        end while (!done4 && cycles < 30);
        check("held_period", cycles, 6);
        check("held_p2", p4, 4);
        start4 = 1'b0;
        @(negedge clk);
        check("held_done_width", done4, 0);

        // Reset during the 2nd RUN cycle of 5*5
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd5; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy4, 0);
        check("midrst_done", done4, 0);
        check("midrst_p", p4, 0);
        repeat (2) @(negedge clk);
        check("midrst_done_held", done4, 0);
        rst_n = 1'b1;
        run_mult(1'b0, 8'd2, 8'd3, 16'd6, "m2x3_after_rst");

        // N=8 directed
        run_mult(1'b1, 8'd255, 8'd255, 16'd65025, "w255x255");
        run_mult(1'b1, 8'd200, 8'd3, 16'd600, "w200x3");
        run_mult(1'b1, 8'd17, 8'd13, 16'd221, "w17x13");
        run_mult(1'b1, 8'd128, 8'd2, 16'd256, "w128x2");
        run_mult(1'b1, 8'd170, 8'd85, 16'd14450, "w170x85");
        run_mult(1'b1, 8'd1, 8'd1, 16'd1, "w1x1");
        run_mult(1'b1, 8'd0, 8'd255, 16'd0, "w0x255");

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
`default_nettype wire
